// File: rtl/hazard_scoreboard_pkg.sv
// Shared decode constants, instruction classes, stall-cause encoding and the
// counter-width helper for the hazard scoreboard.
package hazard_scoreboard_pkg;

  // Primary opcodes
  localparam logic [5:0] OpRtype  = 6'b000000;
  localparam logic [5:0] OpBgez   = 6'b000001;
  localparam logic [5:0] OpBeq    = 6'b000100;
  localparam logic [5:0] OpBne    = 6'b000101;
  localparam logic [5:0] OpBlez   = 6'b000110;
  localparam logic [5:0] OpBgtz   = 6'b000111;
  localparam logic [5:0] OpAddi   = 6'b001000;
  localparam logic [5:0] OpBltz   = 6'b001001;
  localparam logic [5:0] OpSlti   = 6'b001010;
  localparam logic [5:0] OpAndi   = 6'b001100;
  localparam logic [5:0] OpOri    = 6'b001101;
  localparam logic [5:0] OpXori   = 6'b001110;
  localparam logic [5:0] OpLw     = 6'b100011;
  localparam logic [5:0] OpSw     = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FnSll    = 6'b000000;
  localparam logic [5:0] FnSrl    = 6'b000010;
  localparam logic [5:0] FnSra    = 6'b000011;
  localparam logic [5:0] FnMul    = 6'b011000;
  localparam logic [5:0] FnDiv    = 6'b011010;
  localparam logic [5:0] FnAdd    = 6'b100000;
  localparam logic [5:0] FnSub    = 6'b100010;
  localparam logic [5:0] FnAnd    = 6'b100100;
  localparam logic [5:0] FnOr     = 6'b100101;
  localparam logic [5:0] FnSlt    = 6'b101010;

  typedef enum logic [1:0] {
    ClsNone = 2'd0,
    ClsAlu  = 2'd1,
    ClsLoad = 2'd2,
    ClsMd   = 2'd3
  } op_class_e;

  typedef enum logic [1:0] {
    CauseNone   = 2'd0,
    CauseRaw    = 2'd1,
    CauseWaw    = 2'd2,
    CauseStruct = 2'd3
  } stall_cause_e;

  // Width needed to hold the longest latency count.
  function automatic int unsigned cnt_width(input int unsigned load_lat,
                                            input int unsigned md_lat);
    int unsigned m;
    m = (load_lat > md_lat) ? load_lat : md_lat;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_decoder.sv
// Combinational operand-use decoder: which source fields an instruction reads,
// whether and where it writes, and its latency class.
module operand_use_decoder
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned RW = 5
) (
  input  logic [5:0]    op,
  input  logic [5:0]    func,
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  input  logic [RW-1:0] rd,
  output logic          rs_used,
  output logic          rt_used,
  output logic          wr_en,
  output logic [RW-1:0] dest,
  output op_class_e     cls
);

  // Decode opcode/func into operand usage; unknown encodings use nothing.
  always_comb begin
    rs_used = 1'b0;
    rt_used = 1'b0;
    wr_en   = 1'b0;
    dest    = '0;
    cls     = ClsNone;
    unique case (op)
      OpRtype: begin
        unique case (func)
          FnAdd, FnSub, FnAnd, FnOr, FnSlt: begin
            rs_used = 1'b1;
            rt_used = 1'b1;
            wr_en   = 1'b1;
            dest    = rd;
            cls     = ClsAlu;
          end
          FnSll, FnSrl, FnSra: begin
            rt_used = 1'b1;
            wr_en   = 1'b1;
            dest    = rd;
            cls     = ClsAlu;
          end
          FnMul, FnDiv: begin
            rs_used = 1'b1;
            rt_used = 1'b1;
            wr_en   = 1'b1;
            dest    = rd;
            cls     = ClsMd;
          end
          default: ;
        endcase
      end
      OpAddi, OpAndi, OpOri, OpXori, OpSlti: begin
        rs_used = 1'b1;
        wr_en   = 1'b1;
        dest    = rt;
        cls     = ClsAlu;
      end
      OpLw: begin
        rs_used = 1'b1;
        wr_en   = 1'b1;
        dest    = rt;
        cls     = ClsLoad;
      end
      OpSw, OpBeq, OpBne: begin
        rs_used = 1'b1;
        rt_used = 1'b1;
      end
      OpBgez, OpBgtz, OpBlez, OpBltz: begin
        rs_used = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register countdown of cycles until a result
// becomes forwardable, a mul/div occupancy counter, stall generation with
// cause reporting, and a saturating stalled-cycle counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NREG     = 32,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned MD_LAT   = 4,
  parameter int unsigned SCW      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [5:0]               op,
  input  logic [5:0]               func,
  input  logic [$clog2(NREG)-1:0]  rs,
  input  logic [$clog2(NREG)-1:0]  rt,
  input  logic [$clog2(NREG)-1:0]  rd,
  output logic                     stall,
  output logic [1:0]               stall_cause,
  output logic [NREG-1:0]          busy_mask,
  output logic [SCW-1:0]           stall_cnt
);

  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned CW = cnt_width(LOAD_LAT, MD_LAT);
  localparam logic [CW-1:0] LoadLatC = CW'(LOAD_LAT);
  localparam logic [CW-1:0] MdLatC   = CW'(MD_LAT);
  // Unit is free again one cycle before its result becomes forwardable.
  localparam logic [CW-1:0] MdOccC   = CW'(MD_LAT - 1);

  logic [CW-1:0]  r_cnt [NREG];
  logic [CW-1:0]  r_md_cnt;
  logic [SCW-1:0] r_stall_cnt;

  logic           w_rs_used;
  logic           w_rt_used;
  logic           w_wr_en;
  logic [RW-1:0]  w_dest;
  op_class_e      w_cls;
  logic [CW-1:0]  w_lat;
  logic           w_raw;
  logic           w_waw;
  logic           w_struct;
  logic           w_stall;
  logic           w_issue;
  stall_cause_e   w_cause;

  operand_use_decoder #(
    .RW (RW)
  ) u_decoder (
    .op      (op),
    .func    (func),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .rs_used (w_rs_used),
    .rt_used (w_rt_used),
    .wr_en   (w_wr_en),
    .dest    (w_dest),
    .cls     (w_cls)
  );

  // Hazard detection and prioritised cause selection.
  always_comb begin
    w_lat = '0;
    unique case (w_cls)
      ClsLoad: w_lat = LoadLatC;
      ClsMd:   w_lat = MdLatC;
      default: w_lat = '0;
    endcase
    w_raw    = id_valid & ((w_rs_used & (r_cnt[rs] != '0)) |
                           (w_rt_used & (r_cnt[rt] != '0)));
    // An older write still outstanding longer than ours would land after us.
    w_waw    = id_valid & w_wr_en & (w_dest != '0) & (r_cnt[w_dest] > w_lat);
    w_struct = id_valid & (w_cls == ClsMd) & (r_md_cnt != '0);
    w_stall  = w_raw | w_waw | w_struct;
    w_issue  = id_valid & ~w_stall;
    if (w_raw)         w_cause = CauseRaw;
    else if (w_waw)    w_cause = CauseWaw;
    else if (w_struct) w_cause = CauseStruct;
    else               w_cause = CauseNone;
  end

  // Busy mask straight from the counters.
  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      busy_mask[i] = (r_cnt[i] != '0);
    end
  end

  // Countdown per register and for the mul/div unit; an issue load wins over decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
      r_md_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (i == 0)                r_cnt[i] <= '0;
        else if (r_cnt[i] != '0)   r_cnt[i] <= r_cnt[i] - CW'(1);
      end
      if (w_issue && w_wr_en && (w_dest != '0)) begin
        if (w_cls == ClsLoad)    r_cnt[w_dest] <= LoadLatC;
        else if (w_cls == ClsMd) r_cnt[w_dest] <= MdLatC;
      end
      if (r_md_cnt != '0) r_md_cnt <= r_md_cnt - CW'(1);
      if (w_issue && (w_cls == ClsMd)) r_md_cnt <= MdOccC;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + SCW'(1);
    end
  end

  assign stall       = w_stall;
  assign stall_cause = w_cause;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: the driver pushes expected outputs from
// a timestamp-based reference model; a negedge monitor pops and compares.
module tb_hazard_scoreboard;

  localparam int NREG     = 32;
  localparam int LOAD_LAT = 1;
  localparam int MD_LAT   = 4;
  localparam int SCW      = 6;
  localparam int RW       = 5;
  localparam longint SCMAX = (64'd1 << SCW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [5:0]      op;
  logic [5:0]      func;
  logic [RW-1:0]   rs;
  logic [RW-1:0]   rt;
  logic [RW-1:0]   rd;
  logic            stall;
  logic [1:0]      stall_cause;
  logic [NREG-1:0] busy_mask;
  logic [SCW-1:0]  stall_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NREG     (NREG),
    .LOAD_LAT (LOAD_LAT),
    .MD_LAT   (MD_LAT),
    .SCW      (SCW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .op          (op),
    .func        (func),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .stall       (stall),
    .stall_cause (stall_cause),
    .busy_mask   (busy_mask),
    .stall_cnt   (stall_cnt)
  );

  typedef struct {
    int              tag;
    logic            stall;
    logic [1:0]      cause;
    logic [NREG-1:0] busy;
    logic [SCW-1:0]  scnt;
  } exp_t;

  // cls: 0 none, 1 alu, 2 load, 3 mul/div
  typedef struct {
    bit urs;
    bit urt;
    bit wr;
    int dest;
    int cls;
  } dec_t;

  exp_t   q[$];
  exp_t   me;
  int     n_tests = 0;
  int     n_fail  = 0;
  int     tag     = 0;
  // Model: absolute cycle at which each register / the mul-div unit frees up.
  longint cyc     = 0;
  longint ready_at [NREG];
  longint md_free = 0;
  longint scnt_m  = 0;

  function automatic void chk(input string name, input int tg, input longint act,
                              input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s (cycle tag %0d): got %0h, required %0h", name, tg, act, req);
    end
  endfunction

  function automatic dec_t tb_decode(input logic [5:0] o, input logic [5:0] f,
                                     input int s, input int t, input int d);
    dec_t r;
    r = '{0, 0, 0, 0, 0};
    if (o == 6'h00) begin
      if (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) r = '{1, 1, 1, d, 1};
      else if (f inside {6'h00, 6'h02, 6'h03})          r = '{0, 1, 1, d, 1};
      else if (f inside {6'h18, 6'h1a})                 r = '{1, 1, 1, d, 3};
    end else if (o inside {6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a}) r = '{1, 0, 1, t, 1};
    else if (o == 6'h23)                                 r = '{1, 0, 1, t, 2};
    else if (o inside {6'h2b, 6'h04, 6'h05})             r = '{1, 1, 0, 0, 0};
    else if (o inside {6'h01, 6'h07, 6'h06, 6'h09})      r = '{1, 0, 0, 0, 0};
    return r;
  endfunction

  function automatic longint rem(input int r);
    return (ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
  endfunction

  // One clock cycle: drive, predict, let the monitor compare, advance the model.
  task automatic step(input logic rst_v, input logic v, input logic [5:0] o,
                      input logic [5:0] f, input int s, input int t, input int d,
                      output logic dut_stall, output logic [1:0] dut_cause,
                      output logic m_stall);
    dec_t   dc;
    exp_t   e;
    longint lat;
    logic   raw, waw, sth;
    rst = rst_v; id_valid = v; op = o; func = f;
    rs = RW'(s); rt = RW'(t); rd = RW'(d);
    dc  = tb_decode(o, f, s, t, d);
    raw = v && ((dc.urs && rem(s) != 0) || (dc.urt && rem(t) != 0));
    lat = (dc.cls == 2) ? LOAD_LAT : (dc.cls == 3) ? MD_LAT : 0;
    waw = v && dc.wr && dc.dest != 0 && rem(dc.dest) > lat;
    sth = v && dc.cls == 3 && md_free > cyc;
    e.tag   = tag;
    e.stall = raw | waw | sth;
    e.cause = raw ? 2'd1 : waw ? 2'd2 : sth ? 2'd3 : 2'd0;
    for (int i = 0; i < NREG; i++) e.busy[i] = (rem(i) != 0);
    e.scnt = SCW'(scnt_m);
    q.push_back(e);
    @(negedge clk);
    dut_stall = stall;
    dut_cause = stall_cause;
    m_stall   = e.stall;
    if (rst_v) begin
      for (int i = 0; i < NREG; i++) ready_at[i] = 0;
      md_free = 0;
      scnt_m  = 0;
    end else begin
      if (e.stall && scnt_m < SCMAX) scnt_m++;
      if (v && !e.stall && dc.wr && dc.dest != 0) begin
        if (dc.cls == 2) ready_at[dc.dest] = cyc + 1 + LOAD_LAT;
        if (dc.cls == 3) ready_at[dc.dest] = cyc + 1 + MD_LAT;
      end
      if (v && !e.stall && dc.cls == 3) md_free = cyc + MD_LAT;
    end
    cyc++;
    tag++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a, c;
    logic [1:0] b;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 6'h00, 6'h00, 0, 0, 0, a, b, c);
  endtask

  // Hold an instruction in ID until the model says it issues; count DUT stall cycles.
  task automatic issue(input string nm, input logic [5:0] o, input logic [5:0] f,
                       input int s, input int t, input int d,
                       input int exp_stalls, input int exp_cause);
    logic       ds, ms;
    logic [1:0] dc;
    int         nst, first_cause;
    nst = 0; first_cause = 0; ms = 1'b1;
    for (int k = 0; k < 16 && ms; k++) begin
      step(1'b0, 1'b1, o, f, s, t, d, ds, dc, ms);
      if (ds) begin
        if (nst == 0) first_cause = int'(dc);
        nst++;
      end
    end
    chk({nm, " issue bound"}, tag, ms, 0);
    chk({nm, " stall cycles"}, tag, nst, exp_stalls);
    if (exp_stalls > 0) chk({nm, " first cause"}, tag, first_cause, exp_cause);
  endtask

  // Monitor: compare every presented cycle against the oldest prediction.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      me = q.pop_front();
      chk("stall", me.tag, stall, me.stall);
      chk("stall_cause", me.tag, stall_cause, me.cause);
      chk("busy_mask", me.tag, busy_mask, me.busy);
      chk("stall_cnt", me.tag, stall_cnt, me.scnt);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rfn [11];
    logic [5:0] iop [15];
    logic       v, rv, a, c;
    logic [1:0] b;
    logic [5:0] o, f;
    int         s, t, d;
    rfn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02, 6'h03, 6'h18, 6'h1a, 6'h3f};
    iop = '{6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h01,
            6'h07, 6'h06, 6'h09, 6'h3f, 6'h02};
    for (int i = 0; i < NREG; i++) ready_at[i] = 0;
    rst = 1'b1; id_valid = 1'b0; op = '0; func = '0; rs = '0; rt = '0; rd = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    idle(1);                                                // reset state

    // lw $8 then dependent add: one RAW bubble
    issue("lw8", 6'h23, 6'h00, 1, 8, 0, 0, 0);
    issue("add9_8_2", 6'h00, 6'h20, 8, 2, 9, 1, 1);
    chk("stall_cnt after load-use", tag, stall_cnt, 1);
    idle(2);

    // shift reads rt only
    issue("lw8b", 6'h23, 6'h00, 1, 8, 0, 0, 0);
    issue("sll rt=8", 6'h00, 6'h00, 0, 8, 9, 1, 1);
    idle(2);
    issue("lw8c", 6'h23, 6'h00, 1, 8, 0, 0, 0);
    issue("sll rs=8 rt=3", 6'h00, 6'h00, 8, 3, 9, 0, 0);
    idle(2);

    // mul then dependent addi: four RAW cycles
    issue("mul5", 6'h00, 6'h18, 1, 2, 5, 0, 0);
    issue("addi6_5", 6'h08, 6'h00, 5, 6, 0, 4, 1);
    idle(5);

    // mul then lw to same dest: WAW for three cycles
    issue("mul5b", 6'h00, 6'h18, 1, 2, 5, 0, 0);
    issue("lw5", 6'h23, 6'h00, 1, 5, 0, 3, 2);
    chk("busy5 after lw5", tag, busy_mask[5], 1);
    idle(5);

    // back-to-back mul: structural for three cycles
    issue("mul5c", 6'h00, 6'h18, 1, 2, 5, 0, 0);
    issue("mul7", 6'h00, 6'h18, 1, 2, 7, 3, 3);
    idle(5);

    // $0 is never busy
    issue("lw0", 6'h23, 6'h00, 1, 0, 0, 0, 0);
    issue("add1_0_0", 6'h00, 6'h20, 0, 0, 1, 0, 0);

    // reset with a pending load
    issue("lw8d", 6'h23, 6'h00, 1, 8, 0, 0, 0);
    chk("busy before reset", tag, busy_mask, 32'h100);
    step(1'b1, 1'b0, 6'h00, 6'h00, 0, 0, 0, a, b, c);
    chk("busy after reset", tag, busy_mask, 0);
    chk("stall_cnt after reset", tag, stall_cnt, 0);
    issue("add after reset", 6'h00, 6'h20, 8, 8, 9, 0, 0);

    // randomized traffic on a small register window to provoke hazards
    o = 6'h00; f = 6'h20; s = 0; t = 0; d = 0; c = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!c || $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 2) == 0) begin
          o = 6'h00;
          f = rfn[$urandom_range(0, 10)];
        end else begin
          o = iop[$urandom_range(0, 14)];
          f = 6'($urandom);
        end
        s = $urandom_range(0, 7);
        t = $urandom_range(0, 7);
        d = $urandom_range(0, 7);
      end
      v  = ($urandom_range(0, 7) != 0);
      rv = ($urandom_range(0, 199) == 0);
      step(rv, v, o, f, s, t, d, a, b, c);
    end

    idle(2);
    chk("scoreboard drained", tag, q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
